tusca_sequenciador: RTL and testbench
=====================================

# tusca_sequenciador

Measurement/configuration scheduler for the TUSCA climate controller. It sits between the top-level control unit and the datapath. It periodically triggers a DHT11 reading, supervises the reading with a timeout, and retries failed readings up to a bounded count. It also arbitrates the shared serial/config window against measurements, so that a config reception and a sensor reading are never in flight at the same time.

## Interface
Parameters:
- PERIODO, 100_000_000: cycles between measurement starts (2 s at 50 MHz).
- TIMEOUT_MEDIDA, 5_000_000: max cycles waiting for `pronto_medida`.
- INTERVALO_RETRY, 50_000_000: gap before a retry (DHT11 minimum spacing).
- TIMEOUT_CONFIG, 50_000_000: max cycles the config window stays open.
- MAX_TENTATIVAS, 3: attempts per measurement, range 1..3.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- habilita  in  1  enables periodic measurements.
- definir_config  in  1  config request, level; a rising edge is latched.
- pronto_medida  in  1  one-cycle pulse from the measurement datapath.
- erro_checksum  in  1  DHT11 checksum failure; valid only together with `pronto_medida`.
- pronto_config  in  1  one-cycle pulse when a config frame has been received.
- medir_dht11  out  1  one-cycle start pulse to the DHT11 interface.
- receber_config  out  1  high while the config window is open.
- medida_valida  out  1  one-cycle pulse on a good reading.
- erro_medida  out  1  sticky; set when all attempts fail.
- timeout_config  out  1  one-cycle pulse when the config window expires.
- tentativa  out  2  current attempt index, 0-based.
- ocupado  out  1  high in any state other than ESPERA.
- db_estado  out  3  state encoding.

## Operation
- States and encodings:
  - INICIAL=0, ESPERA=1, MEDE=2, AGUARDA=3, SUCESSO=4, FALHA=5, RETRY=6, CONFIG=7.
- Period counter (`$clog2(PERIODO)` bits):
  - Cleared in INICIAL and MEDE; increments in every other state.
  - Saturates at PERIODO-1.
  - `expirado` = (count == PERIODO-1).
- Wait counter:
  - Single shared counter, cleared on entry to AGUARDA, RETRY and CONFIG.
  - Width sized for the largest of TIMEOUT_MEDIDA, INTERVALO_RETRY and TIMEOUT_CONFIG.
- `pedido_config` flag:
  - Set on a rising edge of `definir_config`; cleared on entry to CONFIG.
- Transitions:
  - INICIAL → ESPERA unconditionally.
  - ESPERA: if `pedido_config` → CONFIG; else if `expirado` && `habilita` → MEDE; else stay. Config wins a simultaneous event; `expirado` stays saturated, so the measurement follows right after CONFIG.
  - MEDE: `medir_dht11`=1 → AGUARDA.
  - AGUARDA:
    - `pronto_medida` && !`erro_checksum` → SUCESSO.
    - `pronto_medida` && `erro_checksum` → FALHA.
    - Wait counter == TIMEOUT_MEDIDA-1 → FALHA.
    - `pronto_medida` takes priority over a timeout in the same cycle.
  - SUCESSO: `medida_valida`=1, `erro_medida`←0, `tentativa`←0 → ESPERA.
  - FALHA:
    - If `tentativa` == MAX_TENTATIVAS-1: `erro_medida`←1, `tentativa`←0 → ESPERA. The next attempt waits for the next period.
    - Otherwise `tentativa`++ → RETRY.
  - RETRY:
    - If !`habilita` → ESPERA, `tentativa`←0.
    - Else if wait counter == INTERVALO_RETRY-1 → MEDE.
  - CONFIG:
    - `receber_config`=1.
    - `pronto_config` → ESPERA.
    - Wait counter == TIMEOUT_CONFIG-1 → ESPERA with `timeout_config`=1 in that cycle.
- Requests and pulses outside their window:
  - `pronto_medida` outside AGUARDA and `pronto_config` outside CONFIG are ignored.
  - A config edge arriving during a measurement is latched and served on return to ESPERA.
- Lowering `habilita` never aborts MEDE/AGUARDA; an in-flight reading completes.
- All outputs are Moore-decoded from the state, except `erro_medida` and `tentativa`, which are registered.

## Timing
- Reset (asynchronous, `reset`=0) values:
  - State = INICIAL.
  - All counters = 0, `pedido_config` = 0.
  - All outputs 0, except `db_estado`=0 and `ocupado`=1 (INICIAL is not ESPERA).
- First measurement: `medir_dht11` is high for exactly the cycle after rising edge PERIODO+1 following reset release, provided `habilita`=1 throughout.
- Measurement latency:
  - `pronto_medida` sampled at edge n → `medida_valida` high after edge n+1 → back in ESPERA after edge n+2.
- Retry spacing:
  - FALHA (1 cycle) + RETRY (INTERVALO_RETRY cycles) + MEDE.
  - The next `medir_dht11` pulse comes INTERVALO_RETRY+2 cycles after the failure is detected.
- Config handshake:
  - A rising edge of `definir_config` seen in ESPERA → `receber_config` high 2 edges later (flag registered, then state).
  - `receber_config` falls on the edge that samples `pronto_config`.
- Measurement start pulses are always ≥ INTERVALO_RETRY cycles apart.

## Test plan
Bench parameters: PERIODO=20, TIMEOUT_MEDIDA=10, INTERVALO_RETRY=5, TIMEOUT_CONFIG=8, MAX_TENTATIVAS=3.
- Reset release with `habilita`=1 → `medir_dht11` pulse after edge 21; then `pronto_medida` with `erro_checksum`=0 three cycles later → one `medida_valida` pulse, `erro_medida`=0.
- `pronto_medida` never arrives → 3 start pulses, each separated by 10+1+5+1 cycles; after the third timeout `erro_medida`=1 and `tentativa`=0. The next successful reading clears `erro_medida`.
- `erro_checksum`=1 on the first attempt, good reading on the second → `tentativa` goes 0→1→0; exactly one `medida_valida` pulse; `erro_medida` stays 0.
- `definir_config` rising edge in the same cycle that `expirado` rises → CONFIG first (`receber_config`=1). Then `pronto_config` → `medir_dht11` pulses 2 cycles later.
- Config window with no `pronto_config` → `receber_config` high for 8 cycles, then a 1-cycle `timeout_config` pulse; `definir_config` held high does not reopen the window until it has toggled.
- `reset` asserted in AGUARDA mid-attempt with `tentativa`=1 → all outputs at reset values within the same cycle, with no clock edge required.

Source files
------------

// File: rtl/tusca_sequenciador_if.sv
// Handshake bundle between the control unit / datapath and the TUSCA scheduler.
// master: control unit / datapath side (drives requests and completion pulses).
// slave : scheduler side (drives start pulses, window, status and debug state).
interface tusca_sequenciador_if;
    logic       habilita;
    logic       definir_config;
    logic       pronto_medida;
    logic       erro_checksum;
    logic       pronto_config;
    logic       medir_dht11;
    logic       receber_config;
    logic       medida_valida;
    logic       erro_medida;
    logic       timeout_config;
    logic [1:0] tentativa;
    logic       ocupado;
    logic [2:0] db_estado;

    modport master (
        output habilita, definir_config, pronto_medida, erro_checksum, pronto_config,
        input  medir_dht11, receber_config, medida_valida, erro_medida, timeout_config,
        input  tentativa, ocupado, db_estado
    );

    modport slave (
        input  habilita, definir_config, pronto_medida, erro_checksum, pronto_config,
        output medir_dht11, receber_config, medida_valida, erro_medida, timeout_config,
        output tentativa, ocupado, db_estado
    );
endinterface

// File: rtl/tusca_sequenciador.sv
// Measurement/configuration scheduler for the TUSCA climate controller.
// Periodically starts a DHT11 reading, supervises it with a timeout, retries failed
// readings a bounded number of times and keeps the config window exclusive of readings.
// Ports:
//   clock  - system clock
//   reset  - asynchronous active-low reset
//   bus    - slave side of tusca_sequenciador_if (requests in, pulses/status out)
module tusca_sequenciador #(
    parameter int unsigned PERIODO         = 100_000_000,
    parameter int unsigned TIMEOUT_MEDIDA  = 5_000_000,
    parameter int unsigned INTERVALO_RETRY = 50_000_000,
    parameter int unsigned TIMEOUT_CONFIG  = 50_000_000,
    parameter int unsigned MAX_TENTATIVAS  = 3
) (
    input logic                  clock,
    input logic                  reset,
    tusca_sequenciador_if.slave  bus
);

    localparam int unsigned PerW    = (PERIODO > 1) ? $clog2(PERIODO) : 1;
    localparam int unsigned WaitMax =
        (TIMEOUT_MEDIDA > INTERVALO_RETRY)
            ? ((TIMEOUT_MEDIDA > TIMEOUT_CONFIG) ? TIMEOUT_MEDIDA : TIMEOUT_CONFIG)
            : ((INTERVALO_RETRY > TIMEOUT_CONFIG) ? INTERVALO_RETRY : TIMEOUT_CONFIG);
    localparam int unsigned WaitW   = (WaitMax > 1) ? $clog2(WaitMax) : 1;

    localparam logic [PerW-1:0]  PerLast = PerW'(PERIODO - 1);
    localparam logic [WaitW-1:0] TMedLast = WaitW'(TIMEOUT_MEDIDA - 1);
    localparam logic [WaitW-1:0] TRetLast = WaitW'(INTERVALO_RETRY - 1);
    localparam logic [WaitW-1:0] TCfgLast = WaitW'(TIMEOUT_CONFIG - 1);
    localparam logic [1:0]       TentLast = 2'(MAX_TENTATIVAS - 1);

    typedef enum logic [2:0] {
        StInicial = 3'd0,
        StEspera  = 3'd1,
        StMede    = 3'd2,
        StAguarda = 3'd3,
        StSucesso = 3'd4,
        StFalha   = 3'd5,
        StRetry   = 3'd6,
        StConfig  = 3'd7
    } estado_e;

    estado_e          state_q, state_d;
    logic [PerW-1:0]  per_q, per_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic             pedido_q, pedido_d;
    logic             def_q;
    logic [1:0]       tent_q, tent_d;
    logic             erro_q, erro_d;
    logic             expirado;
    logic             def_edge;
    logic             entra_espera;

    assign expirado = (per_q == PerLast);
    assign def_edge = bus.definir_config & ~def_q;

    always_comb begin
        state_d = state_q;
        tent_d  = tent_q;
        erro_d  = erro_q;
        unique case (state_q)
            StInicial: state_d = StEspera;
            StEspera: begin
                // Config wins; expirado stays saturated so the reading follows CONFIG.
                if (pedido_q) begin
                    state_d = StConfig;
                end else if (expirado && bus.habilita) begin
                    state_d = StMede;
                end
            end
            StMede: state_d = StAguarda;
            StAguarda: begin
                if (bus.pronto_medida) begin
                    state_d = bus.erro_checksum ? StFalha : StSucesso;
                end else if (wait_q == TMedLast) begin
                    state_d = StFalha;
                end
            end
            StSucesso: begin
                state_d = StEspera;
                erro_d  = 1'b0;
                tent_d  = 2'd0;
            end
            StFalha: begin
                if (tent_q == TentLast) begin
                    state_d = StEspera;
                    erro_d  = 1'b1;
                    tent_d  = 2'd0;
                end else begin
                    state_d = StRetry;
                    tent_d  = tent_q + 2'd1;
                end
            end
            StRetry: begin
                if (!bus.habilita) begin
                    state_d = StEspera;
                    tent_d  = 2'd0;
                end else if (wait_q == TRetLast) begin
                    state_d = StMede;
                end
            end
            StConfig: begin
                if (bus.pronto_config || (wait_q == TCfgLast)) begin
                    state_d = StEspera;
                end
            end
        endcase
    end

    // Counters and the latched config request.
    assign entra_espera = 1'b0;
    always_comb begin
        if (state_q == StInicial || state_q == StMede) begin
            per_d = '0;
        end else if (expirado) begin
            per_d = per_q;
        end else begin
            per_d = per_q + 1'b1;
        end

        if ((state_d != state_q) &&
            (state_d == StAguarda || state_d == StRetry || state_d == StConfig)) begin
            wait_d = '0;
        end else if (wait_q != '1) begin
            wait_d = wait_q + 1'b1;
        end else begin
            wait_d = wait_q;
        end

        // A fresh edge wins over the clear so a request is never lost.
        if (def_edge) begin
            pedido_d = 1'b1;
        end else if (state_d == StConfig && state_q != StConfig) begin
            pedido_d = 1'b0;
        end else begin
            pedido_d = pedido_q | entra_espera;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StInicial;
            per_q    <= '0;
            wait_q   <= '0;
            pedido_q <= 1'b0;
            def_q    <= 1'b0;
            tent_q   <= 2'd0;
            erro_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            per_q    <= per_d;
            wait_q   <= wait_d;
            pedido_q <= pedido_d;
            def_q    <= bus.definir_config;
            tent_q   <= tent_d;
            erro_q   <= erro_d;
        end
    end

    assign bus.medir_dht11    = (state_q == StMede);
    assign bus.receber_config = (state_q == StConfig);
    assign bus.medida_valida  = (state_q == StSucesso);
    // Flags the last cycle of a window that closes without a frame.
    assign bus.timeout_config = (state_q == StConfig) && !bus.pronto_config &&
                                (wait_q == TCfgLast);
    assign bus.ocupado        = (state_q != StEspera);
    assign bus.db_estado      = state_q;
    assign bus.tentativa      = tent_q;
    assign bus.erro_medida    = erro_q;

endmodule

// File: tb/tb_tusca_sequenciador.sv
module tb_tusca_sequenciador;

    logic clock;
    logic reset;
    int   cyc;
    int   checks;
    int   failures;
    logic rcv_prev;

    tusca_sequenciador_if bus ();

    tusca_sequenciador #(
        .PERIODO         (20),
        .TIMEOUT_MEDIDA  (10),
        .INTERVALO_RETRY (5),
        .TIMEOUT_CONFIG  (8),
        .MAX_TENTATIVAS  (3)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Number of rising edges since reset release.
    always @(posedge clock or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef enum int {EvMedir, EvValida, EvTimeout, EvOpen, EvClose} ev_e;
    typedef struct {
        ev_e  kind;
        int   at;
        int   estado;
        int   tent;
        int   erro;
    } exp_t;

    exp_t sb[$];

    task automatic push(input ev_e kind, input int at, input int estado,
                        input int tent, input int erro);
        exp_t e;
        e.kind = kind; e.at = at; e.estado = estado; e.tent = tent; e.erro = erro;
        sb.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic observe(input ev_e kind);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: got %s at cycle %0d expected none",
                     kind.name(), cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.at != cyc || e.estado != int'(bus.db_estado) ||
                e.tent != int'(bus.tentativa) || e.erro != int'(bus.erro_medida)) begin
                failures++;
                $display("FAIL event: got %s@%0d st=%0d t=%0d e=%0d expected %s@%0d st=%0d t=%0d e=%0d",
                         kind.name(), cyc, bus.db_estado, bus.tentativa, bus.erro_medida,
                         e.kind.name(), e.at, e.estado, e.tent, e.erro);
            end
        end
    endtask

    // Monitor: any output event is matched against the head of the scoreboard.
    always @(negedge clock) begin
        if (reset) begin
            if (bus.medir_dht11)                     observe(EvMedir);
            if (bus.medida_valida)                   observe(EvValida);
            if (bus.timeout_config)                  observe(EvTimeout);
            if (bus.receber_config && !rcv_prev)     observe(EvOpen);
            if (!bus.receber_config && rcv_prev)     observe(EvClose);
        end
        rcv_prev <= bus.receber_config;
    end

    task automatic goto(input int n);
        while (cyc < n) @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset              = 1'b0;
        bus.habilita       = 1'b0;
        bus.definir_config = 1'b0;
        bus.pronto_medida  = 1'b0;
        bus.erro_checksum  = 1'b0;
        bus.pronto_config  = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic pulse_medida(input logic chk);
        bus.pronto_medida = 1'b1;
        bus.erro_checksum = chk;
        @(negedge clock);
        bus.pronto_medida = 1'b0;
        bus.erro_checksum = 1'b0;
    endtask

    task automatic pulse_config();
        bus.pronto_config = 1'b1;
        @(negedge clock);
        bus.pronto_config = 1'b0;
    endtask

    task automatic end_test(input string name);
        check(name, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rcv_prev = 1'b0;
        reset    = 1'b0;
        bus.habilita = 1'b0; bus.definir_config = 1'b0; bus.pronto_medida = 1'b0;
        bus.erro_checksum = 1'b0; bus.pronto_config = 1'b0;
        repeat (2) @(negedge clock);

        // Reset values.
        check("rst_db_estado", int'(bus.db_estado), 0);
        check("rst_ocupado", int'(bus.ocupado), 1);
        check("rst_outputs", int'({bus.medir_dht11, bus.receber_config, bus.medida_valida,
                                    bus.erro_medida, bus.timeout_config, bus.tentativa}), 0);

        // Good first reading.
        do_reset();
        bus.habilita = 1'b1;
        push(EvMedir, 21, 2, 0, 0);
        push(EvValida, 25, 4, 0, 0);
        push(EvMedir, 42, 2, 0, 0);
        goto(5);
        check("idle_ocupado", int'(bus.ocupado), 0);
        check("idle_db_estado", int'(bus.db_estado), 1);
        goto(24);
        pulse_medida(1'b0);
        goto(27);
        check("good_erro", int'(bus.erro_medida), 0);
        goto(44);
        end_test("good_pending");

        // Three timeouts, then recovery.
        do_reset();
        bus.habilita = 1'b1;
        push(EvMedir, 21, 2, 0, 0);
        push(EvMedir, 38, 2, 1, 0);
        push(EvMedir, 55, 2, 2, 0);
        push(EvMedir, 76, 2, 0, 1);
        push(EvValida, 79, 4, 0, 1);
        goto(70);
        check("tmo_erro_set", int'(bus.erro_medida), 1);
        check("tmo_tent_clr", int'(bus.tentativa), 0);
        check("tmo_db_estado", int'(bus.db_estado), 1);
        goto(78);
        pulse_medida(1'b0);
        goto(81);
        check("tmo_erro_clr", int'(bus.erro_medida), 0);
        goto(85);
        end_test("tmo_pending");

        // Checksum failure then good retry.
        do_reset();
        bus.habilita = 1'b1;
        push(EvMedir, 21, 2, 0, 0);
        push(EvMedir, 30, 2, 1, 0);
        push(EvValida, 33, 4, 1, 0);
        goto(23);
        pulse_medida(1'b1);
        goto(26);
        check("chk_tent_1", int'(bus.tentativa), 1);
        check("chk_db_retry", int'(bus.db_estado), 6);
        goto(32);
        pulse_medida(1'b0);
        goto(35);
        check("chk_tent_0", int'(bus.tentativa), 0);
        check("chk_erro", int'(bus.erro_medida), 0);
        goto(40);
        end_test("chk_pending");

        // Config request coincides with period expiry.
        do_reset();
        bus.habilita = 1'b1;
        push(EvOpen, 21, 7, 0, 0);
        push(EvClose, 24, 1, 0, 0);
        push(EvMedir, 25, 2, 0, 0);
        goto(19);
        bus.definir_config = 1'b1;
        goto(23);
        pulse_config();
        goto(27);
        end_test("cfgprio_pending");

        // Config window timeout; held request does not reopen.
        do_reset();
        push(EvOpen, 4, 7, 0, 0);
        push(EvTimeout, 11, 7, 0, 0);
        push(EvClose, 12, 1, 0, 0);
        push(EvOpen, 34, 7, 0, 0);
        push(EvClose, 36, 1, 0, 0);
        goto(2);
        bus.definir_config = 1'b1;
        goto(20);
        pulse_config();
        goto(22);
        pulse_medida(1'b0);
        goto(30);
        check("cfg_closed", int'(bus.receber_config), 0);
        bus.definir_config = 1'b0;
        goto(32);
        bus.definir_config = 1'b1;
        goto(35);
        pulse_config();
        goto(40);
        end_test("cfgtmo_pending");

        // Asynchronous reset mid-attempt.
        do_reset();
        bus.habilita = 1'b1;
        push(EvMedir, 21, 2, 0, 0);
        push(EvMedir, 30, 2, 1, 0);
        goto(23);
        pulse_medida(1'b1);
        goto(33);
        check("ar_pre_db", int'(bus.db_estado), 3);
        check("ar_pre_tent", int'(bus.tentativa), 1);
        #2;
        reset = 1'b0;
        #1;
        check("ar_db_estado", int'(bus.db_estado), 0);
        check("ar_ocupado", int'(bus.ocupado), 1);
        check("ar_tentativa", int'(bus.tentativa), 0);
        check("ar_outputs", int'({bus.medir_dht11, bus.receber_config, bus.medida_valida,
                                   bus.erro_medida, bus.timeout_config}), 0);
        end_test("ar_pending");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
